// File: rtl/logic_pod_rle_compressor.sv
// Run-length compressor for one logic-pod channel half: folds edge-free 8-sample
// words into idle counts and queues 32-bit tokens in a small FWFT FIFO.
module logic_pod_rle_compressor #(
    parameter int FIFO_DEPTH = 8,
    parameter int IDLE_BITS  = 22
) (
    input  logic                          clk_312p5mhz,
    input  logic                          rst,
    input  logic [7:0]                    din,
    input  logic                          din_en,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [31:0]                   dout,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int LW        = AW + 1;
    localparam int IDLE_FLD  = 22;
    localparam logic [IDLE_BITS-1:0] IDLE_MAX = '1;

    typedef enum logic [1:0] {
        TOK_LITERAL = 2'b00,
        TOK_START   = 2'b01,
        TOK_END     = 2'b10
    } tok_type_t;

    // Stage 1: register the word and the edge compare against the last level
    logic        en_d;
    logic        prev_level;
    logic        s1_en;
    logic        s1_start;
    logic        s1_end;
    logic        s1_edge;
    logic        s1_level;
    logic [7:0]  s1_din;

    always_ff @(posedge clk_312p5mhz) begin
        if (rst) begin
            en_d       <= 1'b0;
            prev_level <= 1'b0;
            s1_en      <= 1'b0;
            s1_start   <= 1'b0;
            s1_end     <= 1'b0;
            s1_edge    <= 1'b0;
            s1_level   <= 1'b0;
            s1_din     <= '0;
        end else begin
            en_d     <= din_en;
            if (din_en)
                prev_level <= din[7];
            s1_en    <= din_en;
            s1_start <= din_en & ~en_d;
            s1_end   <= ~din_en & en_d;
            s1_edge  <= (din != {8{prev_level}});
            s1_level <= prev_level;
            s1_din   <= din;
        end
    end

    // Stage 2: classify the word and build the token
    logic [IDLE_BITS-1:0] idle_cnt;
    logic [IDLE_BITS-1:0] idle_next;
    logic                 tok_valid;
    tok_type_t            tok_type;
    logic [IDLE_BITS-1:0] tok_idle;
    logic [7:0]           tok_samples;
    logic [IDLE_FLD-1:0]  idle_field;
    logic [31:0]          tok_word;

    always_comb begin
        tok_valid   = 1'b0;
        tok_type    = TOK_LITERAL;
        tok_idle    = '0;
        tok_samples = s1_din;
        idle_next   = idle_cnt;
        if (s1_start) begin
            tok_valid = 1'b1;
            tok_type  = TOK_START;
            idle_next = '0;
        end else if (s1_en) begin
            // A saturated counter is flushed as a literal carrying this word
            if (s1_edge || (idle_cnt == IDLE_MAX)) begin
                tok_valid = 1'b1;
                tok_idle  = idle_cnt;
                idle_next = '0;
            end else begin
                idle_next = idle_cnt + 1'b1;
            end
        end else if (s1_end) begin
            tok_valid   = 1'b1;
            tok_type    = TOK_END;
            tok_idle    = idle_cnt;
            tok_samples = {8{s1_level}};
            idle_next   = '0;
        end
    end

    always_comb begin
        idle_field                = '0;
        idle_field[IDLE_BITS-1:0] = tok_idle;
        tok_word                  = {tok_type, idle_field, tok_samples};
    end

    always_ff @(posedge clk_312p5mhz) begin
        if (rst)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_next;
    end

    // Token FIFO, first-word-fall-through
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          full;
    logic          rd_fire;
    logic          wr_fire;
    logic          drop;

    assign full    = (count == LW'(FIFO_DEPTH));
    assign rd_fire = dout_valid & dout_ready;
    assign wr_fire = tok_valid & (~full | rd_fire);
    assign drop    = tok_valid & full & ~rd_fire;

    always_ff @(posedge clk_312p5mhz) begin
        if (wr_fire)
            mem[wr_ptr] <= tok_word;
    end

    always_ff @(posedge clk_312p5mhz) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_fire)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            // A dropped START re-arms the flag in the same cycle it clears it
            if (drop)
                overflow <= 1'b1;
            else if (s1_start)
                overflow <= 1'b0;
        end
    end

    assign dout_valid = (count != '0);
    assign dout       = dout_valid ? mem[rd_ptr] : '0;
    assign fifo_level = count;

endmodule

// File: tb/tb_logic_pod_rle_compressor.sv
// Directed bench for logic_pod_rle_compressor with a 4-entry FIFO and 4-bit idle counter.
module tb_logic_pod_rle_compressor;

    localparam int DEPTH = 4;
    localparam int IBITS = 4;
    localparam int NVEC  = 52;

    logic        clk_312p5mhz = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_en;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout;
    logic        overflow;
    logic [2:0]  fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    logic_pod_rle_compressor #(.FIFO_DEPTH(DEPTH), .IDLE_BITS(IBITS)) dut (
        .clk_312p5mhz (clk_312p5mhz),
        .rst          (rst),
        .din          (din),
        .din_en       (din_en),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout         (dout),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    always #2 clk_312p5mhz = ~clk_312p5mhz;

    typedef struct {
        logic        en;
        logic [7:0]  d;
        logic        exp_v;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic logic [31:0] tok(logic [1:0] t, int idle, logic [7:0] s);
        return {t, 22'(idle), s};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_word(int c, logic en, logic [7:0] d);
        vecs[c].en = en;
        vecs[c].d  = d;
    endtask

    // Token of the word presented in cycle c shows on dout in cycle c+2
    task automatic exp_tok(int c, logic [31:0] t);
        vecs[c+2].exp_v    = 1'b1;
        vecs[c+2].exp_dout = t;
    endtask

    task automatic drive_word(logic en, logic [7:0] d);
        @(posedge clk_312p5mhz);
        #1;
        din_en = en;
        din    = d;
    endtask

    task automatic wait_token(string name, logic [31:0] exp);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk_312p5mhz);
            if (dout_valid && dout_ready) begin
                check(name, dout, exp);
                got = 1'b1;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no token within budget, expected %h", name, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int extra;

        for (int c = 0; c < NVEC; c++)
            vecs[c] = '{1'b0, 8'h00, 1'b0, 32'h0};

        // Start plus quiet run
        for (int c = 0; c <= 9; c++) set_word(c, 1'b1, 8'h00);
        exp_tok(0, tok(2'b01, 0, 8'h00));
        set_word(10, 1'b0, 8'h00);
        exp_tok(10, tok(2'b10, 9, 8'h00));
        // Edge inside a word, then a boundary edge
        set_word(13, 1'b1, 8'h00);
        exp_tok(13, tok(2'b01, 0, 8'h00));
        for (int c = 14; c <= 16; c++) set_word(c, 1'b1, 8'h00);
        set_word(17, 1'b1, 8'h0F);
        exp_tok(17, tok(2'b00, 3, 8'h0F));
        set_word(18, 1'b1, 8'hFF);
        exp_tok(18, tok(2'b00, 0, 8'hFF));
        set_word(19, 1'b1, 8'h00);
        exp_tok(19, tok(2'b00, 0, 8'h00));
        set_word(20, 1'b1, 8'h00);
        set_word(21, 1'b0, 8'h00);
        exp_tok(21, tok(2'b10, 1, 8'h00));
        // Enable toggling 1-0-1; din ignored while disabled
        set_word(25, 1'b1, 8'hAA);
        exp_tok(25, tok(2'b01, 0, 8'hAA));
        set_word(26, 1'b0, 8'h00);
        exp_tok(26, tok(2'b10, 0, 8'hFF));
        set_word(27, 1'b1, 8'h55);
        exp_tok(27, tok(2'b01, 0, 8'h55));
        set_word(28, 1'b1, 8'h00);
        set_word(29, 1'b0, 8'h00);
        exp_tok(29, tok(2'b10, 1, 8'h00));
        set_word(30, 1'b0, 8'hFF);
        // Idle counter saturation
        set_word(32, 1'b1, 8'hFF);
        exp_tok(32, tok(2'b01, 0, 8'hFF));
        for (int c = 33; c <= 48; c++) set_word(c, 1'b1, 8'hFF);
        exp_tok(48, tok(2'b00, 15, 8'hFF));
        set_word(49, 1'b0, 8'h00);
        exp_tok(49, tok(2'b10, 0, 8'hFF));

        rst        = 1'b1;
        din_en     = 1'b0;
        din        = 8'h00;
        dout_ready = 1'b1;
        repeat (2) @(posedge clk_312p5mhz);
        #1;
        rst = 1'b0;
        @(negedge clk_312p5mhz);
        check("reset dout_valid", 32'(dout_valid), 32'd0);
        check("reset dout", dout, 32'h0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset fifo_level", 32'(fifo_level), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk_312p5mhz);
            #1;
            din_en = vecs[i].en;
            din    = vecs[i].d;
            @(negedge clk_312p5mhz);
            check($sformatf("vec%0d valid", i), 32'(dout_valid), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v)
                check($sformatf("vec%0d dout", i), dout, vecs[i].exp_dout);
        end

        // Backpressure and overflow
        drive_word(1'b0, 8'h00);
        dout_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            drive_word(1'b1, (i % 2) ? 8'hFF : 8'h00);
        repeat (4) drive_word(1'b0, 8'h00);
        @(negedge clk_312p5mhz);
        check("ovf fifo_level full", 32'(fifo_level), 32'd4);
        check("ovf overflow set", 32'(overflow), 32'd1);
        check("ovf dout stable", dout, tok(2'b01, 0, 8'h00));
        drive_word(1'b0, 8'h00);
        dout_ready = 1'b1;
        wait_token("drain0 start", tok(2'b01, 0, 8'h00));
        wait_token("drain1 lit", tok(2'b00, 0, 8'hFF));
        wait_token("drain2 lit", tok(2'b00, 0, 8'h00));
        wait_token("drain3 lit", tok(2'b00, 0, 8'hFF));
        extra = 0;
        repeat (4) begin
            @(negedge clk_312p5mhz);
            if (dout_valid) extra++;
        end
        check("drain extra tokens", 32'(extra), 32'd0);
        check("drain fifo_level", 32'(fifo_level), 32'd0);
        check("drain overflow sticky", 32'(overflow), 32'd1);
        drive_word(1'b1, 8'h00);
        drive_word(1'b0, 8'h00);
        wait_token("restart start", tok(2'b01, 0, 8'h00));
        check("start clears overflow", 32'(overflow), 32'd0);
        wait_token("restart end", tok(2'b10, 0, 8'h00));

        // Reset mid-operation with a full FIFO and overflow set
        drive_word(1'b0, 8'h00);
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            drive_word(1'b1, (i % 2) ? 8'hFF : 8'h00);
        repeat (2) drive_word(1'b1, 8'h00);
        @(negedge clk_312p5mhz);
        check("prerst fifo_level", 32'(fifo_level), 32'd4);
        check("prerst overflow", 32'(overflow), 32'd1);
        @(posedge clk_312p5mhz);
        #1;
        rst    = 1'b1;
        din_en = 1'b0;
        @(posedge clk_312p5mhz);
        #1;
        rst        = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk_312p5mhz);
        check("midrst dout_valid", 32'(dout_valid), 32'd0);
        check("midrst fifo_level", 32'(fifo_level), 32'd0);
        check("midrst overflow", 32'(overflow), 32'd0);
        extra = 0;
        repeat (4) begin
            @(negedge clk_312p5mhz);
            if (dout_valid) extra++;
        end
        check("midrst no end token", 32'(extra), 32'd0);
        drive_word(1'b1, 8'h3C);
        drive_word(1'b0, 8'h00);
        wait_token("postrst start", tok(2'b01, 0, 8'h3C));
        wait_token("postrst end", tok(2'b10, 0, 8'h00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
